// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencing controller: per-state datapath control,
// memory ready handshake, retired-instruction counter, sticky illegal flag.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Option,
    input  logic [5:0]       Function,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       Regdst,
    output logic [1:0]       MemtoReg,
    output logic             Regwrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic [1:0]       Sign,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_JR     = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;

    logic is_rtype, is_addu, is_subu, is_jr;

    // Zero is only consumed by the datapath, qualified by PCWriteCond.
    logic unused_zero_c;
    assign unused_zero_c = Zero;

    // Instruction class decode from the held IR fields.
    always_comb begin
        is_rtype = (Option == OP_RTYPE);
        is_addu  = is_rtype && (Function == FN_ADDU);
        is_subu  = is_rtype && (Function == FN_SUBU);
        is_jr    = is_rtype && (Function == FN_JR);
    end

    // State, retired counter and sticky illegal flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    // Next state, bookkeeping and per-state control outputs.
    always_comb begin
        state_d     = state_q;
        retired_d   = retired_q;
        illegal_d   = illegal_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        Regdst      = 2'b00;
        MemtoReg    = 2'b00;
        Regwrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = ALU_ADD;
        Sign        = 2'b00;
        PCSource    = 2'b00;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                Sign    = 2'b10;
                if (Option == OP_LW || Option == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (is_addu || is_subu || Option == OP_ORI || Option == OP_LUI) begin
                    state_d = S_EXEC;
                end else if (Option == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (Option == OP_J || Option == OP_JAL) begin
                    state_d = S_JUMP;
                end else if (is_jr) begin
                    state_d = S_JR;
                end else begin
                    state_d   = S_FETCH;
                    illegal_d = 1'b1;
                end
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                Sign    = 2'b01;
                state_d = (Option == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg  = 2'b01;
                Regwrite  = 1'b1;
                state_d   = S_FETCH;
                retired_d = retired_q + CNT_W'(1);
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    state_d   = S_FETCH;
                    retired_d = retired_q + CNT_W'(1);
                end
            end
            S_EXEC: begin
                if (is_rtype) begin
                    ALUSrcA = 1'b1;
                    ALUOp   = is_subu ? ALU_SUB : ALU_ADD;
                end else if (Option == OP_ORI) begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOp   = ALU_OR;
                end else begin
                    ALUSrcB = 2'b10;
                    ALUOp   = ALU_LUI;
                end
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                Regwrite  = 1'b1;
                Regdst    = is_rtype ? 2'b01 : 2'b00;
                state_d   = S_FETCH;
                retired_d = retired_q + CNT_W'(1);
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = S_FETCH;
                retired_d   = retired_q + CNT_W'(1);
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                if (Option == OP_JAL) begin
                    Regwrite = 1'b1;
                    Regdst   = 2'b10;
                    MemtoReg = 2'b10;
                end
                state_d   = S_FETCH;
                retired_d = retired_q + CNT_W'(1);
            end
            S_JR: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b11;
                state_d   = S_FETCH;
                retired_d = retired_q + CNT_W'(1);
            end
            default: state_d = S_FETCH;
        endcase

        // Reset kills any in-flight access immediately.
        if (!reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            Regdst      = 2'b00;
            MemtoReg    = 2'b00;
            Regwrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = ALU_ADD;
            Sign        = 2'b00;
            PCSource    = 2'b00;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: instruction-level reference model
// pushes expected per-cycle control; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    localparam int unsigned CW  = 4;
    localparam int          MOD = 1 << CW;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    Option, Function;
    logic          Zero, mem_ready;
    logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0]    Regdst, MemtoReg;
    logic          Regwrite, ALUSrcA;
    logic [1:0]    ALUSrcB;
    logic [2:0]    ALUOp;
    logic [1:0]    Sign, PCSource;
    logic [3:0]    state;
    logic [CW-1:0] retired;
    logic          illegal;

    multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .Option(Option), .Function(Function),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .Regdst(Regdst),
        .MemtoReg(MemtoReg), .Regwrite(Regwrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .Sign(Sign), .PCSource(PCSource),
        .state(state), .retired(retired), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    st;
        logic [20:0]   ctrl;
        logic [CW-1:0] ret;
        logic          ill;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   retired_m = 0;
    logic illegal_m = 1'b0;
    logic [5:0] cur_op = '0, cur_fn = '0;

    // Instruction classes: 0 illegal, 1 lw, 2 sw, 3 addu, 4 subu, 5 ori,
    // 6 lui, 7 beq, 8 j, 9 jal, 10 jr
    function automatic int class_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: begin
                if (fn == 6'b100001) return 3;
                if (fn == 6'b100011) return 4;
                if (fn == 6'b001000) return 10;
                return 0;
            end
            6'b100011: return 1;
            6'b101011: return 2;
            6'b001101: return 5;
            6'b001111: return 6;
            6'b000100: return 7;
            6'b000010: return 8;
            6'b000011: return 9;
            default:   return 0;
        endcase
    endfunction

    // Expected control word for a state code, instruction and mem_ready.
    function automatic logic [20:0] exp_ctrl(input int st, input int cls, input logic mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, rw, srca;
        logic [1:0] rd, m2r, srcb, sgn, pcs;
        logic [2:0] aop;
        {pcw, pcwc, iord, mrd, mwr, irw, rw, srca} = '0;
        {rd, m2r, srcb, sgn, pcs} = '0;
        aop = 3'b000;
        case (st)
            0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            1:  begin srcb = 2'b11; sgn = 2'b10; end
            2:  begin srca = 1; srcb = 2'b10; sgn = 2'b01; end
            3:  begin iord = 1; mrd = 1; end
            4:  begin m2r = 2'b01; rw = 1; end
            5:  begin iord = 1; mwr = 1; end
            6:  begin
                    if (cls == 3)      begin srca = 1; end
                    else if (cls == 4) begin srca = 1; aop = 3'b001; end
                    else if (cls == 5) begin srca = 1; srcb = 2'b10; aop = 3'b010; end
                    else               begin srcb = 2'b10; aop = 3'b011; end
                end
            7:  begin rw = 1; rd = (cls == 3 || cls == 4) ? 2'b01 : 2'b00; end
            8:  begin srca = 1; aop = 3'b001; pcwc = 1; pcs = 2'b01; end
            9:  begin
                    pcw = 1; pcs = 2'b10;
                    if (cls == 9) begin rw = 1; rd = 2'b10; m2r = 2'b10; end
                end
            10: begin pcw = 1; pcs = 2'b11; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, rd, m2r, rw, srca, srcb, aop, sgn, pcs};
    endfunction

    function automatic logic [20:0] dut_ctrl();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, Regdst,
                MemtoReg, Regwrite, ALUSrcA, ALUSrcB, ALUOp, Sign, PCSource};
    endfunction

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // One clock cycle of stimulus plus its expected response.
    task automatic cyc(input int st, input logic mr);
        exp_t e;
        @(posedge clk);
        #1;
        Option    = cur_op;
        Function  = cur_fn;
        mem_ready = mr;
        Zero      = 1'($urandom);
        e.st   = 4'(st);
        e.ctrl = exp_ctrl(st, class_of(cur_op, cur_fn), mr);
        e.ret  = CW'(retired_m);
        e.ill  = illegal_m;
        q.push_back(e);
    endtask

    // Whole instruction: fetch waits wf, memory waits wm.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int wf, input int wm);
        int cls;
        cur_op = op;
        cur_fn = fn;
        cls = class_of(op, fn);
        for (int i = 0; i <= wf; i++) cyc(0, i == wf);
        cyc(1, 1'($urandom));
        case (cls)
            0: begin illegal_m = 1'b1; return; end
            1: begin
                   cyc(2, 1'($urandom));
                   for (int i = 0; i <= wm; i++) cyc(3, i == wm);
                   cyc(4, 1'($urandom));
               end
            2: begin
                   cyc(2, 1'($urandom));
                   for (int i = 0; i <= wm; i++) cyc(5, i == wm);
               end
            3, 4, 5, 6: begin cyc(6, 1'($urandom)); cyc(7, 1'($urandom)); end
            7:    cyc(8, 1'($urandom));
            8, 9: cyc(9, 1'($urandom));
            default: cyc(10, 1'($urandom));
        endcase
        retired_m = (retired_m + 1) % MOD;
    endtask

    // Checks that everything is quiescent while reset is held.
    task automatic chk_reset_state(input string tag);
        chk({tag, "_ctrl"},    int'(dut_ctrl()), 0);
        chk({tag, "_state"},   int'(state), 0);
        chk({tag, "_retired"}, int'(retired), 0);
        chk({tag, "_illegal"}, int'(illegal), 0);
    endtask

    // Monitor: compare DUT against the oldest expected entry each cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e, g;
            e = q.pop_front();
            g = {state, dut_ctrl(), retired, illegal};
            n_cmp++;
            if (g != e) begin
                n_err++;
                $display("FAIL cycle_check @%0t: got st=%0d ctrl=%h ret=%0d ill=%b, want st=%0d ctrl=%h ret=%0d ill=%b",
                         $time, g.st, g.ctrl, g.ret, g.ill, e.st, e.ctrl, e.ret, e.ill);
            end
        end
    end

    logic [5:0] op_tab [10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b001101,
                                6'b001111, 6'b000100, 6'b000010, 6'b000011, 6'b000000};
    logic [5:0] fn_tab [10] = '{6'd0, 6'd0, 6'b100001, 6'b100011, 6'd0,
                                6'd0, 6'd0, 6'd0, 6'd0, 6'b001000};

    initial begin
        reset = 1'b0; mem_ready = 1'b0; Zero = 1'b0;
        Option = 6'd0; Function = 6'd0;
        #3;
        chk_reset_state("init");
        #9 reset = 1'b1;

        run_instr(6'b100011, 6'd0, 2, 2);          // lw with waits
        run_instr(6'b000000, 6'b100001, 0, 0);     // addu
        run_instr(6'b000100, 6'd0, 0, 0);          // beq
        run_instr(6'b000100, 6'd0, 0, 0);          // beq
        run_instr(6'b000011, 6'd0, 0, 0);          // jal
        run_instr(6'b000000, 6'b001000, 0, 0);     // jr
        run_instr(6'b111111, 6'd0, 0, 0);          // illegal opcode
        run_instr(6'b001101, 6'd0, 1, 0);          // ori
        run_instr(6'b001111, 6'd0, 0, 0);          // lui
        run_instr(6'b000000, 6'b100011, 0, 0);     // subu
        run_instr(6'b101011, 6'd0, 0, 1);          // sw
        run_instr(6'b000010, 6'd0, 0, 0);          // j
        run_instr(6'b000000, 6'b000111, 0, 0);     // illegal funct

        for (int n = 0; n < 60; n++) begin
            int idx;
            idx = $urandom_range(0, 10);
            if (idx == 10) run_instr(6'($urandom), 6'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
            else           run_instr(op_tab[idx], fn_tab[idx], $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // sw stuck in MEMWR, then a half-cycle reset pulse.
        cur_op = 6'b101011; cur_fn = 6'd0;
        cyc(0, 1'b1); cyc(1, 1'b0); cyc(2, 1'b0); cyc(5, 1'b0); cyc(5, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        chk_reset_state("midreset");
        #4 reset = 1'b1;
        retired_m = 0;
        illegal_m = 1'b0;
        run_instr(6'b000000, 6'b100001, 0, 0);     // addu after reset
        run_instr(6'b000100, 6'd0, 0, 0);          // beq after reset

        for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
        #6;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencing controller for the MIPS datapath. It replaces single-cycle decode with a state machine that issues per-cycle control to a shared-memory datapath (PC, IR, MDR, A/B, ALUOut registers).
- Memory accesses stall on a ready handshake.
- Keeps a retired-instruction counter and a sticky illegal-instruction flag.

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- Option  in  6  IR[31:26], stable from DECODE onward
- Function  in  6  IR[5:0]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if Zero
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  IR load
- Regdst  out  2  00=rt, 01=rd, 10=$31
- MemtoReg  out  2  00=ALUOut, 01=MDR, 10=PC
- Regwrite  out  1  register file write
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  00=B, 01=const 4, 10=ext imm, 11=ext imm<<2
- ALUOp  out  3  000 add, 001 sub, 010 or, 011 imm<<16
- Sign  out  2  00=zero-ext, 01=sign-ext, 10=sign-ext (branch)
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=rs
- state  out  4  current state code
- retired  out  CNT_W  instructions completed
- illegal  out  1  sticky illegal-instruction flag

Behaviour:
- Supported instructions: addu (0/100001), subu (0/100011), jr (0/001000), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, JR 10. Codes 11-15 go to FETCH on the next edge.
- Unlisted control outputs are 0 in every state.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00.
  - IRWrite=PCWrite=mem_ready (Mealy).
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, Sign=10, ALUOp=add (branch target into ALUOut).
  - Next state by opcode: lw/sw -> MEMADR; R-type addu/subu, ori, lui -> EXEC; beq -> BRANCH; j/jal -> JUMP; R-type jr -> JR.
  - Any other opcode or funct: FETCH, set illegal, do not count.
- MEMADR: ALUSrcA=1, ALUSrcB=10, Sign=01, ALUOp=add. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1, MemRead=1. Holds until mem_ready=1, then MEMWB.
- MEMWB: Regdst=00, MemtoReg=01, Regwrite=1. Next state FETCH.
- MEMWR: IorD=1, MemWrite=1. Holds until mem_ready=1, then FETCH.
- EXEC (always followed by ALUWB):
  - R-type: ALUSrcA=1, ALUSrcB=00; ALUOp=add for addu, sub for subu.
  - ori: ALUSrcA=1, ALUSrcB=10, Sign=00, ALUOp=or.
  - lui: ALUSrcB=10, Sign=00, ALUOp=011.
- ALUWB: Regwrite=1, MemtoReg=00, Regdst=01 for R-type else 00. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCWriteCond=1, PCSource=01. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10. For jal also Regwrite=1, Regdst=10, MemtoReg=10 (PC already holds PC+4). Next state FETCH.
- JR: PCWrite=1, PCSource=11. Next state FETCH.
- retired counter:
  - Increments by 1 on each edge that goes from MEMWB, MEMWR (when mem_ready=1), ALUWB, BRANCH, JUMP or JR to FETCH.
  - Wraps modulo 2^CNT_W.
- illegal: set on the illegal DECODE edge; cleared only by reset.
- Reset (reset=0, asynchronous):
  - state=FETCH, retired=0, illegal=0.
  - All control outputs are forced to 0 combinationally while reset=0, including MemRead in FETCH.
  - A reset mid-access drops MemWrite/MemRead immediately. The access is abandoned and nothing is counted.
  - After release, the first edge evaluates FETCH normally.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

Test Plan:
- lw, mem_ready low 2 cycles in FETCH and 2 in MEMRD -> states 0,0,0,1,2,3,3,3,4,0. Regwrite=1 only in state 4, MemtoReg=01, retired 0->1.
- addu (Option=0, Function=100001), mem_ready=1 -> states 0,1,6,7,0. In EXEC ALUOp=000, ALUSrcB=00. In ALUWB Regdst=01, Regwrite=1.
- beq with Zero=1, then beq with Zero=0 -> each takes 3 cycles (0,1,8). PCWriteCond=1, PCSource=01 in BRANCH. retired +2.
- jal -> JUMP with PCWrite=1, PCSource=10, Regwrite=1, Regdst=10, MemtoReg=10. jr -> JR with PCSource=11.
- Option=111111 -> DECODE returns to FETCH, illegal=1 persists across later valid instructions, retired unchanged.
- sw with mem_ready held 0 in MEMWR, reset pulsed low for half a cycle -> MemWrite=0 immediately, state=0, retired=0, illegal=0. Preload retired to 2^CNT_W-1 and retire one instruction -> retired wraps to 0.
